// File: rtl/uart_rx.sv
// Oversampled UART receiver: 1 start, DATA_WIDTH data bits (LSB first), optional parity, 1 stop.
// Each bit is a 3-sample majority vote at mid-bit; the result is reported with one-cycle strobes.
module uart_rx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESCALE_WD = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESCALE_WD-1:0] Prescale,
  input  logic                   parity_enable,
  input  logic                   parity_type,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   Data_Valid,
  output logic                   Parity_Error,
  output logic                   Stop_Error
);

  localparam int unsigned BIT_CNT_WD = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_WD-1:0] LAST_BIT = BIT_CNT_WD'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [PRESCALE_WD-1:0] edge_cnt;
  logic [PRESCALE_WD-1:0] prescale_q;
  logic [BIT_CNT_WD-1:0]  bit_cnt;
  logic                   parity_en_q;
  logic                   parity_type_q;
  logic                   parity_bit;
  logic [2:0]             samples;
  logic [DATA_WIDTH-1:0]  shift_q;

  logic [PRESCALE_WD-1:0] half_c;
  logic                   last_tick_c;
  logic                   bit_c;
  logic                   parity_err_c;
  logic                   stop_err_c;

  // Bit timing and majority-vote decision, all relative to the frame's latched prescale
  assign half_c       = prescale_q >> 1;
  assign last_tick_c  = (edge_cnt == (prescale_q - PRESCALE_WD'(1)));
  assign bit_c        = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);
  assign parity_err_c = parity_en_q & (parity_bit != ((^shift_q) ^ parity_type_q));
  assign stop_err_c   = ~bit_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      edge_cnt      <= '0;
      prescale_q    <= '0;
      bit_cnt       <= '0;
      parity_en_q   <= 1'b0;
      parity_type_q <= 1'b0;
      parity_bit    <= 1'b0;
      samples       <= '0;
      shift_q       <= '0;
      P_DATA        <= '0;
      Data_Valid    <= 1'b0;
      Parity_Error  <= 1'b0;
      Stop_Error    <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        // The detect cycle is tick 0 of the start bit; frame settings are frozen here
        if (!RX_IN) begin
          state         <= START;
          edge_cnt      <= PRESCALE_WD'(1);
          prescale_q    <= Prescale;
          parity_en_q   <= parity_enable;
          parity_type_q <= parity_type;
        end
      end else begin
        edge_cnt <= last_tick_c ? '0 : edge_cnt + PRESCALE_WD'(1);

        if (edge_cnt == (half_c - PRESCALE_WD'(1))) samples[0] <= RX_IN;
        if (edge_cnt == half_c)                     samples[1] <= RX_IN;
        if (edge_cnt == (half_c + PRESCALE_WD'(1))) samples[2] <= RX_IN;

        if (last_tick_c) begin
          case (state)
            START: begin
              if (bit_c) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift_q[bit_cnt] <= bit_c;
              bit_cnt          <= bit_cnt + BIT_CNT_WD'(1);
              if (bit_cnt == LAST_BIT) state <= parity_en_q ? PARITY : STOP;
            end
            PARITY: begin
              parity_bit <= bit_c;
              state      <= STOP;
            end
            STOP: begin
              state        <= IDLE;
              Stop_Error   <= stop_err_c;
              Parity_Error <= parity_err_c;
              if (!stop_err_c && !parity_err_c) begin
                Data_Valid <= 1'b1;
                P_DATA     <= shift_q;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
